// File: rtl/branch_predict_unit_pkg.sv
// Purpose: shared CPU constants for branch decode and 2-bit direction counters.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package branch_predict_unit_pkg;

   // Conditional-branch funct3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // 2-bit saturating direction counter; bit 1 is the taken prediction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam ctr_t CTR_RST = WNT;

   // funct3 = 01x has no branch meaning
   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3[2:1] != 2'b01);
   endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Purpose: next-state function of a 2-bit saturating up/down counter.
// Latency: combinational.
// Backpressure: none.
// Ports: cur = present count, up = count up (else down), nxt = next count.
module sat_counter2
   import branch_predict_unit_pkg::*;
(
   input  ctr_t cur,
   input  logic up,
   output ctr_t nxt
);

   always_comb begin
      nxt = cur;
      if (up) begin
         if (cur != ST) nxt = ctr_t'(cur + 2'd1);
      end else begin
         if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Purpose: branch direction predictor (2-bit counter table) and execute-stage resolver.
// Latency: prediction and resolution combinational; table/counter updates on the next clk edge.
// Backpressure: none; every valid resolving branch is consumed in its cycle.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   fetch_pc -> pred_taken      - fetch-side prediction
//   ex_valid, ex_is_branch, ex_pc, ex_funct3, ex_pred_taken - execute-stage branch info
//   brun -> / breq, brlt <-     - comparator signedness select and results
//   ex_taken, mispredict        - resolved outcome and redirect flag
//   branch_count, mispredict_count - performance counters (wrap modulo 2^32)
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int ENTRIES = 32
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_pred_taken,
   output logic        brun,
   input  logic        breq,
   input  logic        brlt,
   output logic        ex_taken,
   output logic        mispredict,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);

   ctr_t             tbl [ENTRIES];
   logic [IDX_W-1:0] fidx;
   logic [IDX_W-1:0] xidx;
   logic             taken;
   logic             resolve;
   ctr_t             ctr_nxt;
   logic             unused_pc_bits;

   // Untagged direct-mapped index; aliasing PCs share a counter
   assign fidx = fetch_pc[IDX_W+1:2];
   assign xidx = ex_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                             ex_pc[31:IDX_W+2], ex_pc[1:0]};

   // Read is the registered table value: a same-cycle update is not bypassed
   assign pred_taken = tbl[fidx][1];

   // BLTU/BGEU have funct3[1] set; signed compares clear it
   assign brun = ex_funct3[1];

   always_comb begin
      taken = 1'b0;
      case (ex_funct3)
         F3_BEQ:           taken = breq;
         F3_BNE:           taken = !breq;
         F3_BLT,  F3_BLTU: taken = brlt;
         F3_BGE,  F3_BGEU: taken = !brlt;
         default:          taken = 1'b0;
      endcase
   end

   assign resolve    = ex_valid & ex_is_branch & f3_legal(ex_funct3) & !rst;
   assign ex_taken   = resolve & taken;
   assign mispredict = resolve & (taken != ex_pred_taken);

   sat_counter2 u_ctr (
      .cur (tbl[xidx]),
      .up  (taken),
      .nxt (ctr_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= CTR_RST;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (resolve) begin
         tbl[xidx]    <= ctr_nxt;
         branch_count <= branch_count + 32'd1;
         if (mispredict) mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Purpose: self-checking bench for branch_predict_unit using an expectation queue.
// Latency: expectations are checked on the falling edge of the cycle they were driven in.
// Backpressure: n/a.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] fetch_pc = '0;
   logic        pred_taken;
   logic        ex_valid = 1'b0;
   logic        ex_is_branch = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [2:0]  ex_funct3 = '0;
   logic        ex_pred_taken = 1'b0;
   logic        brun;
   logic        breq = 1'b0;
   logic        brlt = 1'b0;
   logic        ex_taken;
   logic        mispredict;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   branch_predict_unit #(.ENTRIES(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_pc         (fetch_pc),
      .pred_taken       (pred_taken),
      .ex_valid         (ex_valid),
      .ex_is_branch     (ex_is_branch),
      .ex_pc            (ex_pc),
      .ex_funct3        (ex_funct3),
      .ex_pred_taken    (ex_pred_taken),
      .brun             (brun),
      .breq             (breq),
      .brlt             (brlt),
      .ex_taken         (ex_taken),
      .mispredict       (mispredict),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    cyc;
      string name;
      int    pred;
      int    tk;
      int    mis;
      int    brun;
      int    bc;
      int    mc;
   } expect_t;

   expect_t sbq[$];
   expect_t cur_e;
   int      cyc = 0;
   int      n_cmp = 0;
   int      n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input int exp);
      if (exp < 0) return;
      n_cmp++;
      if (act !== exp[31:0]) begin
         n_bad++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: pops every expectation tagged with the current cycle
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
         cur_e = sbq.pop_front();
         cmp(cur_e.name, "pred_taken", {31'b0, pred_taken}, cur_e.pred);
         cmp(cur_e.name, "ex_taken",   {31'b0, ex_taken},   cur_e.tk);
         cmp(cur_e.name, "mispredict", {31'b0, mispredict}, cur_e.mis);
         cmp(cur_e.name, "brun",       {31'b0, brun},       cur_e.brun);
         cmp(cur_e.name, "branch_count",     branch_count,     cur_e.bc);
         cmp(cur_e.name, "mispredict_count", mispredict_count, cur_e.mc);
      end
   end

   // Drive one cycle of inputs and queue the hand-computed response (-1 = don't check)
   task automatic step(input string nm, input logic [31:0] fpc, input logic rs,
                       input logic v, input logic b, input logic [31:0] epc,
                       input logic [2:0] f3, input logic ep, input logic eq, input logic lt,
                       input int e_pred, input int e_tk, input int e_mis, input int e_brun,
                       input int e_bc, input int e_mc);
      expect_t e;
      @(posedge clk);
      #1;
      fetch_pc = fpc; rst = rs; ex_valid = v; ex_is_branch = b; ex_pc = epc;
      ex_funct3 = f3; ex_pred_taken = ep; breq = eq; brlt = lt;
      e.cyc = cyc; e.name = nm; e.pred = e_pred; e.tk = e_tk; e.mis = e_mis;
      e.brun = e_brun; e.bc = e_bc; e.mc = e_mc;
      sbq.push_back(e);
   endtask

   task automatic idle(input string nm, input logic [31:0] fpc, input int e_pred,
                       input int e_bc, input int e_mc);
      step(nm, fpc, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0,
           e_pred, 0, 0, 0, e_bc, e_mc);
   endtask

   initial begin
      // Reset held with a live taken BEQ: outputs must stay gated
      step("rst_gate0", 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
      step("rst_gate1", 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) idle("sweep", 32'(i * 4), 0, 0, 0);

      // Train 0x40 taken: 01 -> 10 -> 11, then saturate, then walk back down
      step("beq_t1", 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
      step("beq_t2", 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1, 1, 1, 0, 1, 1);
      idle("after_t2", 32'h40, 1, 2, 2);
      step("beq_t3", 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 3'b000, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 2, 2);
      idle("sat_hi", 32'h40, 1, 3, 2);
      step("beq_nt1", 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 3, 2);
      idle("after_nt1", 32'h40, 1, 4, 3);
      step("beq_nt2", 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 4, 3);
      idle("after_nt2", 32'h40, 0, 5, 4);

      // funct3 decode and brun select
      step("bltu", 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 3'b110, 1'b0, 1'b0, 1'b1, 0, 1, 1, 1, 5, 4);
      step("bge",  32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 3'b101, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 6, 5);
      step("ill010", 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 3'b010, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1, 7, 5);
      step("ill011", 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 3'b011, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 7, 5);
      step("bne",  32'h14, 1'b0, 1'b1, 1'b1, 32'h14, 3'b001, 1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 7, 5);
      step("blt",  32'h14, 1'b0, 1'b1, 1'b1, 32'h14, 3'b100, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 8, 5);
      idle("after_blt", 32'h14, 0, 9, 6);

      // Same-cycle read/write of one entry, then alias 0x80 / 0x00
      step("collide", 32'h80, 1'b0, 1'b1, 1'b1, 32'h80, 3'b000, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0, 9, 6);
      idle("post_collide", 32'h80, 1, 10, 7);
      idle("alias_00", 32'h00, 1, 10, 7);

      // Non-resolving cycles leave state alone
      step("no_valid", 32'h04, 1'b0, 1'b0, 1'b1, 32'h04, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 10, 7);
      idle("after_nv", 32'h04, 0, 10, 7);
      step("no_branch", 32'h04, 1'b0, 1'b1, 1'b0, 32'h04, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 10, 7);
      idle("after_nb", 32'h04, 0, 10, 7);

      // Reset mid-stream with a resolving branch in the same cycle
      step("rst_mid", 32'h00, 1'b1, 1'b1, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 10, 7);
      idle("post_rst0", 32'h00, 0, 0, 0);
      for (int i = 0; i < 32; i++) idle("sweep2", 32'(i * 4), 0, 0, 0);
      // One taken resolve must flip an entry that reset to weak-NT
      step("wnt_chk", 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0);
      idle("wnt_flip", 32'h40, 1, 1, 1);

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      if (sbq.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
